// File: rtl/seq_event_logger.sv
// seq_event_logger: watches the four-in-a-row detector's match flag z and
// input bit w. It counts detection events, measures the length of the current
// match run and keeps the longest run seen. Results go to HEX3..HEX0 and LEDR.
module seq_event_logger #(
  parameter int CNT_W = 8
) (
  input  logic [0:0] KEY,
  input  logic [0:0] SW,
  input  logic       w,
  input  logic       z,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [9:0] LEDR
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic clk;
  logic rst;

  state_t           state, state_nx;
  logic [CNT_W-1:0] evt_cnt, evt_nx;
  logic [CNT_W-1:0] run_len, run_nx;
  logic [CNT_W-1:0] max_run, max_nx;
  logic             pol, pol_nx;

  logic [7:0] evt8, max8, run8;

  assign clk = KEY[0];
  assign rst = SW[0];

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Active-low seven-segment decode, segment order g..a on bits [6:0].
  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // State and counter registers. Reset clears everything, which also
  // discards a run that is still in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      evt_cnt <= '0;
      run_len <= '0;
      max_run <= '0;
      pol     <= 1'b0;
    end else begin
      state   <= state_nx;
      evt_cnt <= evt_nx;
      run_len <= run_nx;
      max_run <= max_nx;
      pol     <= pol_nx;
    end
  end

  // Next-state and counter updates. A polarity flip while z stays high
  // starts a new event without passing through IDLE.
  always_comb begin
    state_nx = state;
    evt_nx   = evt_cnt;
    run_nx   = run_len;
    pol_nx   = pol;
    case (state)
      IDLE: begin
        if (z) begin
          state_nx = RUN;
          evt_nx   = sat_inc(evt_cnt);
          pol_nx   = w;
          run_nx   = CNT_ONE;
        end
      end
      RUN: begin
        if (!z) begin
          state_nx = IDLE;
        end else if (w == pol) begin
          run_nx = sat_inc(run_len);
        end else begin
          evt_nx = sat_inc(evt_cnt);
          pol_nx = w;
          run_nx = CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    max_nx = (run_nx > max_run) ? run_nx : max_run;
  end

  // Display decode of the registered values, zero-extended to 8 bits.
  always_comb begin
    evt8 = 8'(evt_cnt);
    max8 = 8'(max_run);
    run8 = 8'(run_len);
    HEX0 = hex_seg(evt8[3:0]);
    HEX1 = hex_seg(evt8[7:4]);
    HEX2 = hex_seg(max8[3:0]);
    HEX3 = hex_seg(max8[7:4]);
    LEDR = {(state == RUN), pol, run8};
  end

endmodule
